// File: rtl/mole_whack_detector.sv
// mole_whack_detector
// -------------------
// Whack-a-mole core. A free-running 16-bit LFSR picks which hole the next
// mole appears on. Each mole stays up for UP_CYCLES cycles unless the player
// hits it, and consecutive moles are separated by GAP_CYCLES idle cycles. The
// block produces the one-cycle event pulses consumed by the score counter.
//
// Parameters:
//   NUM_HOLES  - number of holes/buttons (power of two, 2..16)
//   UP_CYCLES  - cycles a mole stays visible when not hit (>= 1)
//   GAP_CYCLES - cycles with no mole between moles (>= 1)
//   LFSR_SEED  - non-zero reset value of the LFSR
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   game-running level; low forces the FSM back to IDLE
//   btn     in   debounced synchronous button levels, one per hole
//   mole    out  one-hot visible mole, or all zero
//   whacked out  one-cycle pulse on a hit of the visible mole
//   missed  out  one-cycle pulse when a mole times out
//   wrong   out  one-cycle pulse on a wrong-hole hit
//
// Build option:
//   MOLE_WRONG_HIT_EN - when defined, a press on any other hole ends the mole
//                       and pulses wrong. When undefined, such presses are
//                       ignored and wrong is tied low.

module mole_whack_detector #(
  parameter int          NUM_HOLES  = 4,
  parameter int          UP_CYCLES  = 50_000_000,
  parameter int          GAP_CYCLES = 25_000_000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] btn,
  output logic [NUM_HOLES-1:0] mole,
  output logic                 whacked,
  output logic                 missed,
  output logic                 wrong
);

  localparam int IDX_W   = $clog2(NUM_HOLES);
  localparam int MAX_CYC = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  // The counter only ever holds a reload value minus one.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] UP_LOAD  = CNT_W'(UP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2
  } state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [15:0]          lfsr_reg;
  logic [NUM_HOLES-1:0] btn_q_reg;
  logic [NUM_HOLES-1:0] mole_reg;
  logic                 whacked_reg;
  logic                 missed_reg;

  logic                 lfsr_fb;
  logic [NUM_HOLES-1:0] btn_edge;
  logic [NUM_HOLES-1:0] hole_onehot;
  logic                 hit;

  // Fibonacci feedback for taps 16,14,13,11 (shifting towards bit 0).
  assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];

  // Per-hole rising-edge detect and decode of the LFSR's low bits into the
  // one-hot pattern the next mole would take.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_HOLES; gi++) begin : g_hole
      assign btn_edge[gi]    = btn[gi] & ~btn_q_reg[gi];
      assign hole_onehot[gi] = (lfsr_reg[IDX_W-1:0] == IDX_W'(gi));
    end
  endgenerate

  // mole_reg holds the latched hole as a one-hot mask while in UP, so the
  // hit test is a simple mask against the button edges. A button already
  // held when the mole rose has btn_q set and therefore never produces an edge.
  assign hit = |(btn_edge & mole_reg);

`ifdef MOLE_WRONG_HIT_EN
  logic wrong_reg;
  logic wrong_hit;

  assign wrong_hit = |(btn_edge & ~mole_reg);
  assign wrong     = wrong_reg;
`else
  assign wrong     = 1'b0;
`endif

  assign mole    = mole_reg;
  assign whacked = whacked_reg;
  assign missed  = missed_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      lfsr_reg    <= LFSR_SEED;
      btn_q_reg   <= '0;
      mole_reg    <= '0;
      whacked_reg <= 1'b0;
      missed_reg  <= 1'b0;
`ifdef MOLE_WRONG_HIT_EN
      wrong_reg   <= 1'b0;
`endif
    end else begin
      // The LFSR and the button history run regardless of game state so the
      // hole sequence depends only on time since reset.
      lfsr_reg    <= {lfsr_fb, lfsr_reg[15:1]};
      btn_q_reg   <= btn;
      whacked_reg <= 1'b0;
      missed_reg  <= 1'b0;
`ifdef MOLE_WRONG_HIT_EN
      wrong_reg   <= 1'b0;
`endif

      if (!start) begin
        // Stopping the game wins over any event that would fire this cycle.
        state_reg <= IDLE;
        mole_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            mole_reg  <= '0;
            cnt_reg   <= GAP_LOAD;
            state_reg <= GAP;
          end

          GAP: begin
            if (cnt_reg == '0) begin
              mole_reg  <= hole_onehot;
              cnt_reg   <= UP_LOAD;
              state_reg <= UP;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end

          UP: begin
            if (hit) begin
              // A correct hit beats a simultaneous wrong press and a timeout
              // on the same cycle.
              whacked_reg <= 1'b1;
              mole_reg    <= '0;
              cnt_reg     <= GAP_LOAD;
              state_reg   <= GAP;
`ifdef MOLE_WRONG_HIT_EN
            end else if (wrong_hit) begin
              wrong_reg <= 1'b1;
              mole_reg  <= '0;
              cnt_reg   <= GAP_LOAD;
              state_reg <= GAP;
`endif
            end else if (cnt_reg == '0) begin
              missed_reg <= 1'b1;
              mole_reg   <= '0;
              cnt_reg    <= GAP_LOAD;
              state_reg  <= GAP;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end

          default: begin
            state_reg <= IDLE;
            mole_reg  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_whack_detector.sv
`timescale 1ns/1ps

// Self-checking bench for mole_whack_detector with NUM_HOLES=4, UP_CYCLES=8,
// GAP_CYCLES=4. Expected mole positions come from the LFSR definition applied
// to the number of clock edges since reset; expected timing comes from the
// rise/gap/visibility rules. Inputs are driven and outputs sampled on the
// falling edge.
module tb_mole_whack_detector;

  localparam int          NH   = 4;
  localparam int          UPC  = 8;
  localparam int          GAPC = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NH-1:0] btn = '0;
  logic [NH-1:0] mole;
  logic          whacked;
  logic          missed;
  logic          wrong;

  int            passed = 0;
  int            total = 0;
  int            cyc = 0;
  int            last_end = 0;
  int            rise_cyc = 0;
  logic [NH-1:0] cur_mole = '0;

  mole_whack_detector #(
    .NUM_HOLES (NH),
    .UP_CYCLES (UPC),
    .GAP_CYCLES(GAPC),
    .LFSR_SEED (SEED)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .btn    (btn),
    .mole   (mole),
    .whacked(whacked),
    .missed (missed),
    .wrong  (wrong)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset was released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference: the LFSR value after n steps from the seed, and the mole a
  // rise would show when the LFSR had taken n steps before that rise edge.
  function automatic logic [NH-1:0] expected_mole(input int n);
    logic [15:0] l;
    logic [NH-1:0] m;
    l = SEED;
    for (int i = 0; i < n; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    m = '0;
    m[l[1:0]] = 1'b1;
    return m;
  endfunction

  function automatic int hole_of(input logic [NH-1:0] m);
    int h;
    h = 0;
    for (int i = 0; i < NH; i++) if (m[i]) h = i;
    return h;
  endfunction

  function automatic logic [NH+2:0] outs();
    return {mole, whacked, missed, wrong};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until a mole is visible (bounded). n = ticks taken, -1 on timeout;
  // exp = model mole for the edge that raised it.
  task automatic wait_rise(output int n, output logic [NH-1:0] exp);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mole !== '0) begin
        n = i;
        break;
      end
    end
    exp = expected_mole(cyc - 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    btn   = '0;
    repeat (3) @(negedge clk);
    total++;
    if (outs() !== '0) $display("FAIL reset_outputs: got %b, expected %b", outs(), 7'b0);
    else passed++;
    rst_n = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_first_mole();
    logic [NH-1:0] exp;
    start = 1'b1;
    for (int i = 0; i < GAPC; i++) begin
      tick();
      total++;
      if (outs() !== '0) $display("FAIL first_gap edge %0d: got %b, expected %b", i, outs(), 7'b0);
      else passed++;
    end
    tick();
    exp = expected_mole(cyc - 1);
    total++;
    if (outs() !== {exp, 3'b000}) $display("FAIL first_mole: got %b, expected %b", outs(), {exp, 3'b000});
    else passed++;
    cur_mole = exp;
    rise_cyc = cyc;
    $display("first mole at edge %0d hole %0d", cyc - 1, hole_of(exp));
  endtask

  task automatic test_timeout();
    int n;
    logic [NH-1:0] exp;
    for (int v = 2; v <= UPC; v++) begin
      tick();
      total++;
      if (outs() !== {cur_mole, 3'b000}) $display("FAIL timeout_visible cycle %0d: got %b, expected %b", v, outs(), {cur_mole, 3'b000});
      else passed++;
    end
    tick();
    total++;
    if (outs() !== {{NH{1'b0}}, 3'b010}) $display("FAIL timeout_missed: got %b, expected %b", outs(), {{NH{1'b0}}, 3'b010});
    else passed++;
    last_end = cyc;
    tick();
    total++;
    if (outs() !== '0) $display("FAIL timeout_pulse_width: got %b, expected %b", outs(), 7'b0);
    else passed++;
    wait_rise(n, exp);
    total++;
    if (cyc - last_end !== GAPC) $display("FAIL timeout_gap: got %0d, expected %0d", cyc - last_end, GAPC);
    else passed++;
    total++;
    if (mole !== exp) $display("FAIL timeout_next_hole: got %b, expected %b", mole, exp);
    else passed++;
    $display("miss then next mole hole %0d after %0d cycles", hole_of(exp), cyc - last_end);
    cur_mole = exp;
    rise_cyc = cyc;
  endtask

  task automatic test_hit();
    int n;
    int v;
    logic [NH-1:0] exp;
    for (int it = 0; it < 4; it++) begin
      v = (it == 0) ? 3 : (it == 1) ? UPC : int'($urandom_range(1, UPC));
      repeat (v - 1) tick();
      total++;
      if (mole !== cur_mole) $display("FAIL hit_before_press v=%0d: got %b, expected %b", v, mole, cur_mole);
      else passed++;
      btn = cur_mole;
      tick();
      total++;
      if (outs() !== {{NH{1'b0}}, 3'b100}) $display("FAIL hit_whack v=%0d: got %b, expected %b", v, outs(), {{NH{1'b0}}, 3'b100});
      else passed++;
      last_end = cyc;
      btn = '0;
      tick();
      total++;
      if (outs() !== '0) $display("FAIL hit_pulse_width v=%0d: got %b, expected %b", v, outs(), 7'b0);
      else passed++;
      wait_rise(n, exp);
      total++;
      if (cyc - last_end !== GAPC) $display("FAIL hit_gap: got %0d, expected %0d", cyc - last_end, GAPC);
      else passed++;
      total++;
      if (mole !== exp) $display("FAIL hit_next_hole: got %b, expected %b", mole, exp);
      else passed++;
      $display("hit on up cycle %0d, next mole hole %0d", v, hole_of(exp));
      cur_mole = exp;
      rise_cyc = cyc;
    end
  endtask

  task automatic test_held();
    int n;
    logic [NH-1:0] exp;
    repeat (UPC - 1) tick();
    tick();
    total++;
    if (missed !== 1'b1) $display("FAIL held_setup_missed: got %b, expected 1", missed);
    else passed++;
    last_end = cyc;
    btn = '1;
    wait_rise(n, exp);
    total++;
    if (cyc - last_end !== GAPC) $display("FAIL held_gap: got %0d, expected %0d", cyc - last_end, GAPC);
    else passed++;
    cur_mole = exp;
    rise_cyc = cyc;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (outs() !== {cur_mole, 3'b000}) $display("FAIL held_no_hit %0d: got %b, expected %b", i, outs(), {cur_mole, 3'b000});
      else passed++;
    end
    btn = '0;
    tick();
    total++;
    if (outs() !== {cur_mole, 3'b000}) $display("FAIL held_release: got %b, expected %b", outs(), {cur_mole, 3'b000});
    else passed++;
    btn = cur_mole;
    tick();
    total++;
    if (outs() !== {{NH{1'b0}}, 3'b100}) $display("FAIL held_repress_whack: got %b, expected %b", outs(), {{NH{1'b0}}, 3'b100});
    else passed++;
    last_end = cyc;
    btn = '0;
    wait_rise(n, exp);
    total++;
    if (cyc - last_end !== GAPC) $display("FAIL held_next_gap: got %0d, expected %0d", cyc - last_end, GAPC);
    else passed++;
    total++;
    if (mole !== exp) $display("FAIL held_next_hole: got %b, expected %b", mole, exp);
    else passed++;
    $display("held button ignored, re-press whacked, next mole hole %0d", hole_of(exp));
    cur_mole = exp;
    rise_cyc = cyc;
  endtask

  task automatic test_wrong();
    int n;
    int v;
    int w;
    logic [NH-1:0] exp;
    logic [NH-1:0] wmask;
    for (int it = 0; it < 3; it++) begin
      w = (hole_of(cur_mole) + int'($urandom_range(1, NH - 1))) % NH;
      wmask = '0;
      wmask[w] = 1'b1;
      v = int'($urandom_range(1, UPC - 1));
      repeat (v - 1) tick();
      btn = wmask;
      tick();
`ifdef MOLE_WRONG_HIT_EN
      total++;
      if (outs() !== {{NH{1'b0}}, 3'b001}) $display("FAIL wrong_hit v=%0d: got %b, expected %b", v, outs(), {{NH{1'b0}}, 3'b001});
      else passed++;
      last_end = cyc;
      btn = '0;
      tick();
      total++;
      if (outs() !== '0) $display("FAIL wrong_pulse_width: got %b, expected %b", outs(), 7'b0);
      else passed++;
`else
      total++;
      if (outs() !== {cur_mole, 3'b000}) $display("FAIL wrong_ignored v=%0d: got %b, expected %b", v, outs(), {cur_mole, 3'b000});
      else passed++;
      btn = '0;
      repeat (UPC - v - 1) tick();
      tick();
      total++;
      if (outs() !== {{NH{1'b0}}, 3'b010}) $display("FAIL wrong_then_missed: got %b, expected %b", outs(), {{NH{1'b0}}, 3'b010});
      else passed++;
      last_end = cyc;
`endif
      wait_rise(n, exp);
      total++;
      if (cyc - last_end !== GAPC) $display("FAIL wrong_gap: got %0d, expected %0d", cyc - last_end, GAPC);
      else passed++;
      total++;
      if (mole !== exp) $display("FAIL wrong_next_hole: got %b, expected %b", mole, exp);
      else passed++;
      $display("wrong hole %0d pressed on up cycle %0d, next mole hole %0d", w, v, hole_of(exp));
      cur_mole = exp;
      rise_cyc = cyc;
    end
    // Correct and wrong hole pressed on the same edge.
    w = (hole_of(cur_mole) + int'($urandom_range(1, NH - 1))) % NH;
    wmask = '0;
    wmask[w] = 1'b1;
    v = int'($urandom_range(1, UPC));
    repeat (v - 1) tick();
    btn = cur_mole | wmask;
    tick();
    total++;
    if (outs() !== {{NH{1'b0}}, 3'b100}) $display("FAIL both_pressed: got %b, expected %b", outs(), {{NH{1'b0}}, 3'b100});
    else passed++;
    last_end = cyc;
    btn = '0;
    wait_rise(n, exp);
    total++;
    if (cyc - last_end !== GAPC) $display("FAIL both_gap: got %0d, expected %0d", cyc - last_end, GAPC);
    else passed++;
    $display("correct+wrong hole %0d together on up cycle %0d", w, v);
    cur_mole = exp;
    rise_cyc = cyc;
  endtask

  task automatic test_abort();
    int n;
    int v;
    logic [NH-1:0] exp;
    v = int'($urandom_range(1, UPC));
    repeat (v - 1) tick();
    start = 1'b0;
    btn = cur_mole;  // a hit on the same edge must be suppressed
    tick();
    total++;
    if (outs() !== '0) $display("FAIL abort_clear v=%0d: got %b, expected %b", v, outs(), 7'b0);
    else passed++;
    btn = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outs() !== '0) $display("FAIL abort_stays_idle %0d: got %b, expected %b", i, outs(), 7'b0);
      else passed++;
    end
    start = 1'b1;
    wait_rise(n, exp);
    total++;
    if (n !== GAPC + 1) $display("FAIL abort_restart_latency: got %0d, expected %0d", n, GAPC + 1);
    else passed++;
    total++;
    if (mole !== exp) $display("FAIL abort_restart_hole: got %b, expected %b", mole, exp);
    else passed++;
    $display("abort on up cycle %0d, restart mole hole %0d", v, hole_of(exp));
    cur_mole = exp;
    rise_cyc = cyc;
  endtask

  task automatic test_async_reset();
    int n;
    logic [NH-1:0] exp;
    repeat (int'($urandom_range(1, 5))) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== '0) $display("FAIL async_reset_clear: got %b, expected %b", outs(), 7'b0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_rise(n, exp);
    total++;
    if (n !== GAPC + 1) $display("FAIL async_reset_restart_latency: got %0d, expected %0d", n, GAPC + 1);
    else passed++;
    total++;
    if (mole !== exp) $display("FAIL async_reset_lfsr_reseed: got %b, expected %b", mole, exp);
    else passed++;
    $display("async reset mid-up, restart mole hole %0d", hole_of(exp));
    cur_mole = exp;
    rise_cyc = cyc;
  endtask

  initial begin
    test_reset();
    test_first_mole();
    test_timeout();
    test_hit();
    test_held();
    test_wrong();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
